motor_pulse_sequencer: RTL and testbench
========================================

Name: motor_pulse_sequencer

Overview:
Converts one motor command (left/right step period in clocks, pulse count) into step-pulse trains for the two TRACK3R motor drivers. It sits between the direction-to-command mapper and the motor driver pins. It latches a command on a start strobe and runs both pulse trains concurrently until each has emitted its count. It reports busy and done, and supports abort.

Parameters:
PERIOD_W, 21, width of the period inputs (clocks per step)
COUNT_W, 10, width of the pulse-count input and counters
MIN_PERIOD, 2, smallest legal nonzero period; nonzero periods below this are clamped up to it

Ports:
iClk  input  1  system clock
iRST  input  1  asynchronous, active-high reset
iLeftPeriod  input  PERIOD_W  left motor step period in clocks; 0 = left motor idle for this command
iRightPeriod  input  PERIOD_W  right motor step period in clocks; 0 = right motor idle for this command
iNumPulses  input  COUNT_W  pulses per motor for this command
iStart  input  1  command strobe, sampled only in IDLE
iStop  input  1  abort request, acts in RUN
oLeftStep  output  1  left step output
oRightStep  output  1  right step output
oBusy  output  1  high while in RUN
oDone  output  1  one-cycle pulse on normal completion
oLeftCount  output  COUNT_W  left pulses completed in current/last command
oRightCount  output  COUNT_W  right pulses completed in current/last command

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; latched command and counters cleared.
- States: IDLE, RUN, DONE.
- IDLE, iStart=1:
  - Latch both periods (clamped to MIN_PERIOD if nonzero and below it) and iNumPulses.
  - Clear both counts and phase counters.
  - If iNumPulses=0 or both periods are 0: go to DONE.
  - Otherwise: go to RUN.
- IDLE, iStart=0: stay in IDLE.
- Input changes after the latch edge have no effect on the running command.
- RUN, per motor with nonzero period P and count below N:
  - Phase counter runs 0..P-1, starting at 0 in the first RUN cycle.
  - Step output is high while phase < P>>1, else low (registered, so the first RUN cycle drives high).
  - When phase=P-1: phase wraps to 0 and the motor's count increments.
- RUN, motor finished: once its count reaches N, or its period is 0, its step output holds 0 and its phase freezes.
- RUN → DONE: in the cycle after the slower motor's final phase=P-1 cycle, i.e. after both motors are finished.
  - With a nonzero period on both motors, RUN lasts N*max(Pl,Pr) cycles.
- DONE: oDone=1 for exactly one cycle, oBusy=0, then IDLE. Counts hold until the next start.
- oBusy = (state==RUN).
- iStop in RUN has priority over completion in the same cycle:
  - Next state is IDLE, both step outputs 0, oDone stays 0.
  - Counts hold their partial values.
- iStop in IDLE or DONE is ignored.
- iStart while in RUN or DONE is ignored; it is not queued.
- Counters never exceed N; no wrap is possible because N ≤ 2^COUNT_W-1.

Decomposition:
- Shared package (motor_pkg):
  - State enum {IDLE, RUN, DONE}.
  - PERIOD_W, COUNT_W and MIN_PERIOD constants.
  - Command-table constants used by the direction mapper (65000, 85000, 20, 40).
- One sub-module, step_channel, instantiated twice (left/right):
  - Inputs: clock, reset, load, run, period, N.
  - Outputs: step, count, finished.
- The top level holds the FSM and clamping only.

Test Plan:
- Reset mid-RUN (Pl=Pr=10, N=5, iRST after 23 cycles) -> all outputs 0 immediately (async), state IDLE, no oDone.
- Pl=4, Pr=6, N=3, iStart at edge k:
  - oLeftStep = 1100 x3, then 0.
  - oRightStep = 111000 x3.
  - oBusy high for cycles k+1..k+18.
  - oDone=1 only in cycle k+19.
  - Final counts 3/3.
- N=0, or Pl=Pr=0 -> oBusy never high, oDone=1 one cycle after start, no step edges, counts 0.
- Pl=0, Pr=8, N=2 -> oLeftStep stays 0, left count 0; right produces 2 pulses (4 high/4 low); oDone at k+17.
- Pl=1, Pr=3, N=2 -> left clamped to period 2 (10 x2); right high 1 cycle, low 2 cycles (100 x2); oDone at k+7.
- iStop asserted in the 5th RUN cycle (Pl=Pr=4, N=10) -> next cycle IDLE, steps 0, oDone never asserted, counts 1/1.
- iStart pulsed again during RUN -> ignored; the completion cycle matches the original command.
- Latched-input check: change iLeftPeriod during RUN -> pulse timing unchanged.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the TRACK3R motor pulse path.
package motor_pkg;

   // Datapath widths and the smallest period the step generator can honour.
   localparam int PERIOD_W   = 21;
   localparam int COUNT_W    = 10;
   localparam int MIN_PERIOD = 2;

   // Command-table values consumed by the direction-to-command mapper.
   localparam int CMD_PERIOD_FAST  = 65000;
   localparam int CMD_PERIOD_SLOW  = 85000;
   localparam int CMD_PULSES_SHORT = 20;
   localparam int CMD_PULSES_LONG  = 40;

   // Sequencer control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/motor_pulse_sequencer_if.sv
// Command/status bundle between the command source and the pulse sequencer.
interface motor_pulse_sequencer_if #(
   parameter int PERIOD_W = motor_pkg::PERIOD_W,
   parameter int COUNT_W  = motor_pkg::COUNT_W
);
   logic [PERIOD_W-1:0] iLeftPeriod;
   logic [PERIOD_W-1:0] iRightPeriod;
   logic [COUNT_W-1:0]  iNumPulses;
   logic                iStart;
   logic                iStop;
   logic                oLeftStep;
   logic                oRightStep;
   logic                oBusy;
   logic                oDone;
   logic [COUNT_W-1:0]  oLeftCount;
   logic [COUNT_W-1:0]  oRightCount;
   logic [1:0]          oDbgState;

   // Handshake: iStart is a one-cycle command strobe honoured only when the
   // sequencer is idle (oBusy=0, oDone=0); there is no ready/backpressure,
   // a strobe seen while busy is dropped. oDone marks completion for one cycle.
   modport master (
      output iLeftPeriod, iRightPeriod, iNumPulses, iStart, iStop,
      input  oLeftStep, oRightStep, oBusy, oDone, oLeftCount, oRightCount, oDbgState
   );

   modport slave (
      input  iLeftPeriod, iRightPeriod, iNumPulses, iStart, iStop,
      output oLeftStep, oRightStep, oBusy, oDone, oLeftCount, oRightCount, oDbgState
   );
endinterface

// File: rtl/step_channel.sv
// One motor's step generator: latches period/count on load, then emits
// N square-ish pulses of the given period while run is asserted.
module step_channel #(
   parameter int PERIOD_W = 21,
   parameter int COUNT_W  = 10
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_load,
   input  logic                i_run,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic [COUNT_W-1:0]  i_num,
   output logic                o_step,
   output logic [COUNT_W-1:0]  o_count,
   output logic                o_finished
);

   logic [PERIOD_W-1:0] r_period;
   logic [COUNT_W-1:0]  r_num;
   logic [PERIOD_W-1:0] r_phase;
   logic [COUNT_W-1:0]  r_count;
   logic                r_step;

   logic                w_active;
   logic                w_last_phase;
   logic [PERIOD_W-1:0] w_half;
   logic [PERIOD_W-1:0] w_phase_nxt;
   logic [COUNT_W-1:0]  w_count_nxt;

   assign w_active     = (r_period != '0) && (r_count < r_num);
   assign w_last_phase = (r_phase == (r_period - PERIOD_W'(1)));
   assign w_half       = r_period >> 1;
   assign w_phase_nxt  = w_last_phase ? '0 : (r_phase + PERIOD_W'(1));
   assign w_count_nxt  = w_last_phase ? (r_count + COUNT_W'(1)) : r_count;

   // Finished is look-ahead: true when this channel has nothing left to do
   // once the current cycle ends, so the FSM leaves RUN without a dead cycle.
   assign o_finished = !w_active || (w_last_phase && (w_count_nxt == r_num));
   assign o_step     = r_step;
   assign o_count    = r_count;

   // Command latch, phase/pulse counters and the registered step level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_period <= '0;
         r_num    <= '0;
         r_phase  <= '0;
         r_count  <= '0;
         r_step   <= 1'b0;
      end else if (i_load) begin
         r_period <= i_period;
         r_num    <= i_num;
         r_phase  <= '0;
         r_count  <= '0;
         // Pre-load the first high phase so the first RUN cycle drives high.
         r_step   <= ((i_period >> 1) != '0) && (i_num != '0);
      end else if (i_run && w_active) begin
         r_phase  <= w_phase_nxt;
         r_count  <= w_count_nxt;
         r_step   <= (w_count_nxt < r_num) && (w_phase_nxt < w_half);
      end else begin
         r_step   <= 1'b0;
      end
   end

endmodule

// File: rtl/motor_pulse_sequencer.sv
// Latches a left/right motor command and runs both step trains together,
// reporting busy/done and honouring an abort while running.
module motor_pulse_sequencer #(
   parameter int PERIOD_W   = motor_pkg::PERIOD_W,
   parameter int COUNT_W    = motor_pkg::COUNT_W,
   parameter int MIN_PERIOD = motor_pkg::MIN_PERIOD
) (
   input  logic                iClk,
   input  logic                iRST,
   input  logic [PERIOD_W-1:0] iLeftPeriod,
   input  logic [PERIOD_W-1:0] iRightPeriod,
   input  logic [COUNT_W-1:0]  iNumPulses,
   input  logic                iStart,
   input  logic                iStop,
   output logic                oLeftStep,
   output logic                oRightStep,
   output logic                oBusy,
   output logic                oDone,
   output logic [COUNT_W-1:0]  oLeftCount,
   output logic [COUNT_W-1:0]  oRightCount,
   output logic [1:0]          oDbgState
);
   import motor_pkg::*;

   state_t              r_state;
   logic                r_busy;
   logic                r_done;

   logic [PERIOD_W-1:0] w_left_period;
   logic [PERIOD_W-1:0] w_right_period;
   logic                w_load;
   logic                w_run;
   logic                w_left_fin;
   logic                w_right_fin;
   logic                w_empty_cmd;

   // Nonzero periods below the minimum cannot form a high and a low phase.
   assign w_left_period  = ((iLeftPeriod != '0) && (iLeftPeriod < PERIOD_W'(MIN_PERIOD)))
                           ? PERIOD_W'(MIN_PERIOD) : iLeftPeriod;
   assign w_right_period = ((iRightPeriod != '0) && (iRightPeriod < PERIOD_W'(MIN_PERIOD)))
                           ? PERIOD_W'(MIN_PERIOD) : iRightPeriod;

   assign w_load      = (r_state == IDLE) && iStart;
   // Abort freezes the channels in the same cycle; they then drive 0.
   assign w_run       = (r_state == RUN) && !iStop;
   assign w_empty_cmd = (iNumPulses == '0) || ((iLeftPeriod == '0) && (iRightPeriod == '0));

   step_channel #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) u_left (
      .i_clk      (iClk),
      .i_rst      (iRST),
      .i_load     (w_load),
      .i_run      (w_run),
      .i_period   (w_left_period),
      .i_num      (iNumPulses),
      .o_step     (oLeftStep),
      .o_count    (oLeftCount),
      .o_finished (w_left_fin)
   );

   step_channel #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) u_right (
      .i_clk      (iClk),
      .i_rst      (iRST),
      .i_load     (w_load),
      .i_run      (w_run),
      .i_period   (w_right_period),
      .i_num      (iNumPulses),
      .o_step     (oRightStep),
      .o_count    (oRightCount),
      .o_finished (w_right_fin)
   );

   // Control FSM with registered busy/done flags.
   always_ff @(posedge iClk or posedge iRST) begin
      if (iRST) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (iStart) begin
                  if (w_empty_cmd) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (iStop) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_left_fin && w_right_fin) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign oBusy     = r_busy;
   assign oDone     = r_done;
   assign oDbgState = r_state;

endmodule

// File: tb/tb_motor_pulse_sequencer.sv
// Directed bench for motor_pulse_sequencer: per-cycle checks of both step
// trains, busy/done timing and counts against a small reference model.
module tb_motor_pulse_sequencer;
   localparam int PW = motor_pkg::PERIOD_W;
   localparam int CW = motor_pkg::COUNT_W;

   logic iClk;
   logic iRST;
   int   tests_run;
   int   tests_failed;

   motor_pulse_sequencer_if #(.PERIOD_W(PW), .COUNT_W(CW)) u_if ();

   motor_pulse_sequencer dut (
      .iClk         (iClk),
      .iRST         (iRST),
      .iLeftPeriod  (u_if.iLeftPeriod),
      .iRightPeriod (u_if.iRightPeriod),
      .iNumPulses   (u_if.iNumPulses),
      .iStart       (u_if.iStart),
      .iStop        (u_if.iStop),
      .oLeftStep    (u_if.oLeftStep),
      .oRightStep   (u_if.oRightStep),
      .oBusy        (u_if.oBusy),
      .oDone        (u_if.oDone),
      .oLeftCount   (u_if.oLeftCount),
      .oRightCount  (u_if.oRightCount),
      .oDbgState    (u_if.oDbgState)
   );

   // clock / reset
   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // reference model
   function automatic int clampp(input int p);
      return (p != 0 && p < 2) ? 2 : p;
   endfunction

   function automatic int exp_step(input int p, input int n, input int c);
      int idx;
      if (p == 0 || n == 0) return 0;
      idx = c - 1;
      if (idx >= n * p) return 0;
      return ((idx % p) < (p / 2)) ? 1 : 0;
   endfunction

   function automatic int exp_count(input int p, input int n, input int c);
      int k;
      if (p == 0) return 0;
      k = (c - 1) / p;
      return (k > n) ? n : k;
   endfunction

   // driver: issue a command, then check every cycle until back in IDLE.
   // perturb 1: change left period mid-run; perturb 2: re-strobe start mid-run.
   task automatic run_cmd(input int pl, input int pr, input int n, input int perturb);
      int cl, cr, len, pmax;
      cl   = clampp(pl);
      cr   = clampp(pr);
      pmax = (cl > cr) ? cl : cr;
      len  = (n == 0) ? 0 : n * pmax;
      @(negedge iClk);
      u_if.iLeftPeriod  = PW'(pl);
      u_if.iRightPeriod = PW'(pr);
      u_if.iNumPulses   = CW'(n);
      u_if.iStart       = 1'b1;
      @(negedge iClk);
      u_if.iStart       = 1'b0;
      for (int c = 1; c <= len + 3; c++) begin
         check_val($sformatf("L%0d/R%0d/N%0d c%0d lstep", pl, pr, n, c), u_if.oLeftStep, exp_step(cl, n, c));
         check_val($sformatf("L%0d/R%0d/N%0d c%0d rstep", pl, pr, n, c), u_if.oRightStep, exp_step(cr, n, c));
         check_val($sformatf("L%0d/R%0d/N%0d c%0d busy", pl, pr, n, c), u_if.oBusy, (c <= len) ? 1 : 0);
         check_val($sformatf("L%0d/R%0d/N%0d c%0d done", pl, pr, n, c), u_if.oDone, (c == len + 1) ? 1 : 0);
         check_val($sformatf("L%0d/R%0d/N%0d c%0d lcnt", pl, pr, n, c), u_if.oLeftCount, exp_count(cl, n, c));
         check_val($sformatf("L%0d/R%0d/N%0d c%0d rcnt", pl, pr, n, c), u_if.oRightCount, exp_count(cr, n, c));
         if (c == 3 && perturb == 1) begin
            u_if.iLeftPeriod  = PW'(pl + 7);
            u_if.iRightPeriod = PW'(1);
            u_if.iNumPulses   = CW'(n + 5);
         end
         if (c == 3 && perturb == 2) u_if.iStart = 1'b1;
         if (c == 4) u_if.iStart = 1'b0;
         @(negedge iClk);
      end
      check_val($sformatf("L%0d/R%0d/N%0d end state", pl, pr, n), u_if.oDbgState, 0);
   endtask

   // abort in the 5th RUN cycle
   task automatic stop_test();
      @(negedge iClk);
      u_if.iLeftPeriod  = PW'(4);
      u_if.iRightPeriod = PW'(4);
      u_if.iNumPulses   = CW'(10);
      u_if.iStart       = 1'b1;
      @(negedge iClk);
      u_if.iStart       = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check_val($sformatf("stop c%0d lstep", c), u_if.oLeftStep, exp_step(4, 10, c));
         check_val($sformatf("stop c%0d busy", c), u_if.oBusy, 1);
         if (c == 5) u_if.iStop = 1'b1;
         @(negedge iClk);
      end
      u_if.iStop = 1'b0;
      check_val("stop state", u_if.oDbgState, 0);
      check_val("stop busy", u_if.oBusy, 0);
      check_val("stop lstep", u_if.oLeftStep, 0);
      check_val("stop rstep", u_if.oRightStep, 0);
      check_val("stop lcnt", u_if.oLeftCount, 1);
      check_val("stop rcnt", u_if.oRightCount, 1);
      for (int c = 0; c < 6; c++) begin
         check_val($sformatf("stop no done %0d", c), u_if.oDone, 0);
         @(negedge iClk);
      end
      check_val("stop counts held", u_if.oLeftCount, 1);
   endtask

   // asynchronous reset in the middle of a run
   task automatic reset_test();
      @(negedge iClk);
      u_if.iLeftPeriod  = PW'(10);
      u_if.iRightPeriod = PW'(10);
      u_if.iNumPulses   = CW'(5);
      u_if.iStart       = 1'b1;
      @(negedge iClk);
      u_if.iStart       = 1'b0;
      repeat (23) @(negedge iClk);
      check_val("pre-rst busy", u_if.oBusy, 1);
      check_val("pre-rst lcnt", u_if.oLeftCount, 2);
      #2 iRST = 1'b1;
      #1;
      check_val("rst state", u_if.oDbgState, 0);
      check_val("rst busy", u_if.oBusy, 0);
      check_val("rst done", u_if.oDone, 0);
      check_val("rst lstep", u_if.oLeftStep, 0);
      check_val("rst rstep", u_if.oRightStep, 0);
      check_val("rst lcnt", u_if.oLeftCount, 0);
      check_val("rst rcnt", u_if.oRightCount, 0);
      @(negedge iClk);
      iRST = 1'b0;
      for (int c = 0; c < 10; c++) begin
         check_val($sformatf("post-rst done %0d", c), u_if.oDone, 0);
         check_val($sformatf("post-rst busy %0d", c), u_if.oBusy, 0);
         @(negedge iClk);
      end
   endtask

   // main sequence and final report
   initial begin
      tests_run         = 0;
      tests_failed      = 0;
      iRST              = 1'b1;
      u_if.iLeftPeriod  = '0;
      u_if.iRightPeriod = '0;
      u_if.iNumPulses   = '0;
      u_if.iStart       = 1'b0;
      u_if.iStop        = 1'b0;
      repeat (3) @(negedge iClk);
      check_val("reset state", u_if.oDbgState, 0);
      check_val("reset busy", u_if.oBusy, 0);
      check_val("reset done", u_if.oDone, 0);
      check_val("reset lstep", u_if.oLeftStep, 0);
      check_val("reset lcnt", u_if.oLeftCount, 0);
      iRST = 1'b0;
      @(negedge iClk);
      u_if.iStop = 1'b1;            // ignored in IDLE
      @(negedge iClk);
      u_if.iStop = 1'b0;
      check_val("idle stop ignored", u_if.oDbgState, 0);

      run_cmd(4, 6, 3, 0);
      run_cmd(0, 0, 5, 0);
      run_cmd(10, 12, 0, 0);
      run_cmd(0, 8, 2, 0);
      run_cmd(1, 3, 2, 0);
      run_cmd(5, 3, 4, 1);
      run_cmd(4, 6, 3, 2);
      stop_test();
      reset_test();
      run_cmd(3, 2, 2, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
